serial_adder_sub: RTL and testbench

- Multi-cycle, digit-serial two's-complement adder/subtractor with a start/done handshake.
- Processes DIGIT bits per clock through a ripple chain of full-adder cells. It trades latency for area in datapaths where a full-width carry chain is not needed.
- Parametrised successor to the single-bit gate-level full adder. Adds operand width, digit size, a subtract mode, signed-overflow detection and sequencing.

---
 rtl/serial_adder_sub_if.sv | 27 ++
 rtl/serial_adder_sub.sv | 121 ++++++++++++
 tb/tb_serial_adder_sub.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_sub_if.sv
// Handshake and operand/result bundle for serial_adder_sub.
// The requester drives the master side; the adder sits on the slave side.
interface serial_adder_sub_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, a, b, ci, sub,
    input  ready, busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, ci, sub,
    output ready, busy, done, s, co, ovf
  );
endinterface

// File: rtl/serial_adder_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock through a
// ripple chain of full-adder cells, sequenced by a start/done handshake.
module serial_adder_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_sub_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder_sub: DIGIT must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] s_reg;
  logic             co_reg;
  logic             ovf_reg;

  logic             accept;
  logic             last_digit;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] sum_dig;
  logic [DIGIT:0]   c;

  assign accept     = bus.start && (state_reg != RUN);
  assign last_digit = (cnt_reg == CW'(N - 1));

  assign a_dig = a_reg[int'(cnt_reg) * DIGIT +: DIGIT];
  assign b_dig = b_reg[int'(cnt_reg) * DIGIT +: DIGIT];
  assign c[0]  = carry_reg;

  // One full-adder cell per bit of the digit; the carry ripples LSB to MSB.
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      assign sum_dig[gi] = a_dig[gi] ^ b_dig[gi] ^ c[gi];
      assign c[gi+1]     = (a_dig[gi] & b_dig[gi]) | (c[gi] & (a_dig[gi] ^ b_dig[gi]));
    end
  endgenerate

  always_comb begin
    res_next = res_reg;
    res_next[int'(cnt_reg) * DIGIT +: DIGIT] = sum_dig;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state
  always_comb begin
    bus.ready = (state_reg != RUN);
    bus.busy  = (state_reg == RUN);
    bus.done  = (state_reg == DONE);
  end

  // Subtraction is folded into the operands: a + ~b + !borrow_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      co_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_reg     <= bus.a;
      b_reg     <= bus.b ^ {WIDTH{bus.sub}};
      carry_reg <= bus.ci ^ bus.sub;
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      res_reg   <= res_next;
      carry_reg <= c[DIGIT];
      cnt_reg   <= cnt_reg + 1'b1;
      if (last_digit) begin
        s_reg   <= res_next;
        co_reg  <= c[DIGIT];
        ovf_reg <= c[DIGIT] ^ c[DIGIT-1];
      end
    end
  end

  assign bus.s   = s_reg;
  assign bus.co  = co_reg;
  assign bus.ovf = ovf_reg;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed bench for serial_adder_sub (16/4) plus randomised sweeps of other
// WIDTH/DIGIT configurations against an arithmetic reference.
module tb_serial_adder_sub;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cfg_turn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder_sub_if #(.WIDTH(16)) bus ();

  serial_adder_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs[7] = '{
    '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0}
  };

  // Launch one operation from a negedge; returns on the negedge where done is seen.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        input logic vs, input bit disturb, output int lat, output int busy_n);
    @(negedge clk);
    bus.a = va; bus.b = vb; bus.ci = vc; bus.sub = vs; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      if (disturb && lat == 1) begin
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.ci = 1'b1; bus.sub = 1'b1;
      end
      if (disturb && lat == 2) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_n;
    int gap;
    bit done_seen;
    n_cmp = 0;
    n_err = 0;
    cfg_turn = -1;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.s, bus.co, bus.ovf, bus.done, bus.busy, bus.ready},
          {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, 1'b0, lat, busy_n);
      $display("op %0d: a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d ovf=%0d lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, bus.s, bus.co, bus.ovf, lat);
      check("latency", lat, 4);
      check("busy_cycles", busy_n, 4);
      check("result", {bus.s, bus.co, bus.ovf}, {vecs[i].s, vecs[i].co, vecs[i].ovf});
      @(negedge clk);
      check("done_one_cycle", {bus.done, bus.ready}, 2'b01);
    end

    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, lat, busy_n);
    $display("ignored-start op: s=%h lat=%0d", bus.s, lat);
    check("ignore_start_lat", lat, 4);
    check("ignore_start_s", {bus.s, bus.co, bus.ovf}, {16'h3333, 1'b0, 1'b0});

    // Back-to-back: start held during the DONE cycle
    bus.a = 16'h0001; bus.b = 16'h0002; bus.ci = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_accepted", bus.busy, 1'b1);
    gap = 1;
    while (!bus.done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    $display("back-to-back op: s=%h gap=%0d", bus.s, gap);
    check("b2b_gap", gap, 5);
    check("b2b_s", bus.s, 16'h0003);

    // Abort mid-operation with an asynchronous reset
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-op: s=%h co=%0d ovf=%0d done=%0d busy=%0d",
             bus.s, bus.co, bus.ovf, bus.done, bus.busy);
    check("async_reset", {bus.s, bus.co, bus.ovf, bus.done, bus.busy}, 20'h0);
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      done_seen |= bus.done;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      done_seen |= bus.done;
    end
    check("no_done_after_abort", done_seen, 1'b0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, busy_n);
    $display("post-reset op: s=%h co=%0d ovf=%0d lat=%0d", bus.s, bus.co, bus.ovf, lat);
    check("post_reset", {bus.s, bus.co, bus.ovf}, {16'h0100, 1'b0, 1'b0});

    cfg_turn = 0;
    wait (cfg_turn == 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Other configurations, each swept in turn with random operands.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int W = (gi == 2) ? 8 : (gi == 3) ? 12 : 16;
      localparam int D = (gi == 0) ? 1 : (gi == 1) ? 16 : (gi == 2) ? 2 : 3;

      serial_adder_sub_if #(.WIDTH(W)) cbus ();

      serial_adder_sub #(.WIDTH(W), .DIGIT(D)) cdut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cbus)
      );

      initial begin
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic         vs;
        longint       ua;
        longint       ub;
        longint       sa;
        longint       sb;
        longint       exact;
        logic [W-1:0] es;
        logic         eco;
        logic         eovf;
        int           n;
        int           errs_before;
        cbus.start = 1'b0; cbus.a = '0; cbus.b = '0; cbus.ci = 1'b0; cbus.sub = 1'b0;
        wait (cfg_turn == gi);
        errs_before = n_err;
        for (int k = 0; k < 1000; k++) begin
          va = W'($urandom);
          vb = W'($urandom);
          vc = 1'($urandom);
          vs = 1'($urandom);
          ua = longint'(va);
          ub = longint'(vb);
          sa = longint'($signed(va));
          sb = longint'($signed(vb));
          if (!vs) begin
            exact = ua + ub + longint'(vc);
            es    = W'(exact);
            eco   = (exact >= (64'sd1 <<< W));
            exact = sa + sb + longint'(vc);
          end else begin
            exact = ua - ub - longint'(vc);
            es    = W'(exact);
            eco   = (ua >= ub + longint'(vc));
            exact = sa - sb - longint'(vc);
          end
          eovf = (exact > ((64'sd1 <<< (W - 1)) - 1)) || (exact < -(64'sd1 <<< (W - 1)));

          @(negedge clk);
          cbus.a = va; cbus.b = vb; cbus.ci = vc; cbus.sub = vs; cbus.start = 1'b1;
          @(negedge clk);
          cbus.start = 1'b0;
          n = 0;
          while (!cbus.done && n < 40) begin
            @(negedge clk);
            n++;
          end
          check($sformatf("cfg%0d_%0dx%0d_vec%0d", gi, W, D, k),
                {cbus.done, cbus.co, cbus.ovf, cbus.s}, {1'b1, eco, eovf, es});
          check($sformatf("cfg%0d_latency", gi), n, W / D);
        end
        $display("config W=%0d D=%0d: 1000 vectors, %0d new mismatches", W, D, n_err - errs_before);
        cfg_turn = gi + 1;
      end
    end
  endgenerate

endmodule
